// File: rtl/vector_memory_responder_pkg.sv
// Request/response payload shared by the vector load/store unit and the memory responder.
package vector_memory_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned CORE_W = 4;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } access_t;

  typedef struct packed {
    logic              vld;
    access_t           access_type;
    logic [ID_W-1:0]   access_id;
    logic [CORE_W-1:0] core_id;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   byte_en;
    logic [DATA_W-1:0] data;
  } request_t;

endpackage

// File: rtl/vector_memory_responder.sv
// Single-bank memory responder: in-order request FIFO, byte-masked writes,
// fixed-latency reads and one held response per request.
module vector_memory_responder
  import vector_memory_responder_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = 1024,
  parameter int unsigned REQ_FIFO_DEPTH = 4,
  parameter int unsigned READ_LATENCY   = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  request_t mem_req,
  output logic     req_grant,
  output request_t mem_rsp,
  input  logic     rsp_rcvd,
  output logic     busy
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned FA_W  = $clog2(REQ_FIFO_DEPTH);
  localparam int unsigned PTR_W = FA_W + 1;
  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  request_t          fifo_mem [REQ_FIFO_DEPTH];
  logic [DATA_W-1:0] mem      [MEM_DEPTH];
  request_t          head;
  request_t          cur_req;
  request_t          cur_req_nxt;
  request_t          rsp_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [LAT_W-1:0]  lat_nxt;
  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] rd_word;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              mem_we;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FA_W] != rd_ptr[FA_W]) &&
                      (wr_ptr[FA_W-1:0] == rd_ptr[FA_W-1:0]);
  assign push       = mem_req.vld && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr[FA_W-1:0]];
  assign head_idx   = head.addr[3 +: IDX_W];
  assign cur_idx    = cur_req.addr[3 +: IDX_W];
  assign rd_word    = mem[cur_idx];

  assign req_grant  = !fifo_full;
  assign busy       = !fifo_empty || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[FA_W-1:0]] <= mem_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Memory is never reset; a write is dropped if reset coincides with its pop.
  always_ff @(posedge clk) begin
    if (mem_we && reset) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (head.byte_en[b]) begin
          mem[head_idx][8*b +: 8] <= head.data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!fifo_empty) state_nxt = S_WAIT;
      S_WAIT:    if (lat_cnt == '0) state_nxt = S_RESPOND;
      S_RESPOND: if (rsp_rcvd) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cur_req_nxt = cur_req;
    lat_nxt     = lat_cnt;
    rsp_nxt     = mem_rsp;
    mem_we      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          cur_req_nxt = head;
          lat_nxt     = LAT_W'(READ_LATENCY - 1);
          mem_we      = (head.access_type == ACC_WRITE);
        end
      end
      S_WAIT: begin
        if (lat_cnt == '0) begin
          rsp_nxt      = cur_req;
          rsp_nxt.vld  = 1'b1;
          rsp_nxt.data = (cur_req.access_type == ACC_READ) ? rd_word : '0;
        end else begin
          lat_nxt = lat_cnt - LAT_W'(1);
        end
      end
      S_RESPOND: begin
        if (rsp_rcvd) rsp_nxt = '0;
      end
      default: begin
        rsp_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_req <= '0;
      lat_cnt <= '0;
      mem_rsp <= '0;
    end else begin
      cur_req <= cur_req_nxt;
      lat_cnt <= lat_nxt;
      mem_rsp <= rsp_nxt;
    end
  end

endmodule

// File: tb/tb_vector_memory_responder.sv
// Randomized bench for vector_memory_responder against an in-order word-memory model.
module tb_vector_memory_responder;
  import vector_memory_responder_pkg::*;

  localparam int unsigned EXP_LAT = 4;

  logic     clk = 1'b0;
  logic     reset;
  request_t req;
  logic     req_grant;
  request_t mem_rsp;
  logic     rcvd;
  logic     busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_rsp    = 0;
  int n_stale  = 0;
  logic last_acc = 1'b0;

  logic [63:0] mem_model [int];
  request_t    exp_q [$];
  int          pool [8];

  vector_memory_responder dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (req),
    .req_grant(req_grant),
    .mem_rsp  (mem_rsp),
    .rsp_rcvd (rcvd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[12:3]);
  endfunction

  function automatic request_t mk(input access_t t, input logic [3:0] id, input logic [31:0] a,
                                  input logic [7:0] be, input logic [63:0] d);
    request_t r;
    r.vld         = 1'b1;
    r.access_type = t;
    r.access_id   = id;
    r.core_id     = 4'($urandom);
    r.addr        = a;
    r.byte_en     = be;
    r.data        = d;
    return r;
  endfunction

  // Requests complete in order, so the expected response can be formed at accept time.
  task automatic model_accept(input request_t r);
    request_t    e;
    logic [63:0] w;
    int          i;
    e = r;
    i = widx(r.addr);
    w = mem_model.exists(i) ? mem_model[i] : 64'h0;
    if (r.access_type == ACC_WRITE) begin
      for (int b = 0; b < 8; b++) if (r.byte_en[b]) w[8*b +: 8] = r.data[8*b +: 8];
      mem_model[i] = w;
      e.data = 64'h0;
    end else begin
      e.data = w;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    last_acc = req.vld && req_grant;
    if (last_acc) model_accept(req);
    if (mem_rsp.vld) begin
      if (exp_q.size() == 0) begin
        n_stale++;
      end else begin
        check("rsp", 128'(mem_rsp), 128'(exp_q[0]));
        if (rcvd) begin
          void'(exp_q.pop_front());
          n_rsp++;
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send_one(input request_t r, output request_t seen, output int lat);
    int c0;
    req  = r;
    rcvd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    check("accept", 128'(last_acc), 128'(1));
    req.vld = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 20 && !mem_rsp.vld; i++) tick();
    check("rsp_vld", 128'(mem_rsp.vld), 128'(1));
    lat  = cyc - c0 + 1;
    seen = mem_rsp;
    rcvd = 1'b1;
    tick();
    rcvd = 1'b0;
    check("rsp_clear", 128'(mem_rsp), 128'(0));
  endtask

  function automatic request_t rand_req();
    logic [31:0] a;
    access_t     t;
    a       = $urandom;
    a[12:3] = 10'(pool[$urandom_range(7, 0)]);
    t       = ($urandom_range(1, 0) == 1) ? ACC_WRITE : ACC_READ;
    return mk(t, 4'($urandom), a, 8'($urandom), {$urandom, $urandom});
  endfunction

  initial begin
    request_t seen;
    int       lat;
    int       n_acc;
    int       r0;
    int       s0;

    req   = '0;
    rcvd  = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check("reset_grant", 128'(req_grant), 128'(1));
    check("reset_rsp", 128'(mem_rsp), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));

    // Full write, then read back with exact latency.
    send_one(mk(ACC_WRITE, 4'd0, 32'h40, 8'hFF, 64'h1122334455667788), seen, lat);
    check("wr_latency", 128'(lat), 128'(EXP_LAT));
    check("wr_data_zero", 128'(seen.data), 128'(0));
    send_one(mk(ACC_READ, 4'd1, 32'h40, 8'hFF, 64'h0), seen, lat);
    check("rd_latency", 128'(lat), 128'(EXP_LAT));
    check("rd_data", 128'(seen.data), 128'(64'h1122334455667788));
    check("rd_id", 128'(seen.access_id), 128'(1));

    // Byte-masked write keeps the upper half.
    send_one(mk(ACC_WRITE, 4'd2, 32'h40, 8'h0F, 64'hAAAAAAAAAAAAAAAA), seen, lat);
    send_one(mk(ACC_READ, 4'd3, 32'h40, 8'hFF, 64'h0), seen, lat);
    check("partial_data", 128'(seen.data), 128'(64'h11223344AAAAAAAA));

    // Addresses alias modulo MEM_DEPTH*8.
    send_one(mk(ACC_WRITE, 4'd4, 32'h2040, 8'hFF, 64'd5), seen, lat);
    send_one(mk(ACC_READ, 4'd5, 32'h40, 8'hFF, 64'h0), seen, lat);
    check("wrap_data", 128'(seen.data), 128'(5));

    // Back-pressure: four queued plus one in service.
    rcvd  = 1'b0;
    n_acc = 0;
    r0    = n_rsp;
    for (int k = 0; k < 6; k++) begin
      req = mk(ACC_READ, 4'(k), 32'h40, 8'hFF, 64'h0);
      for (int i = 0; i < 6; i++) begin
        tick();
        if (last_acc) break;
      end
      if (!last_acc) break;
      n_acc++;
      if (k == 4) check("bp_grant_drop", 128'(req_grant), 128'(0));
    end
    check("bp_accepts", 128'(n_acc), 128'(5));
    rcvd = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (last_acc) req.vld = 1'b0;
      if (!req.vld && exp_q.size() == 0 && !mem_rsp.vld) break;
    end
    check("bp_rsp_count", 128'(n_rsp - r0), 128'(6));
    rcvd = 1'b0;

    // Reset while in WAIT with two requests queued.
    req = mk(ACC_READ, 4'd7, 32'h40, 8'hFF, 64'h0);
    tick();
    req = mk(ACC_READ, 4'd8, 32'h40, 8'hFF, 64'h0);
    tick();
    req = mk(ACC_READ, 4'd9, 32'h40, 8'hFF, 64'h0);
    tick();
    req.vld = 1'b0;
    check("mid_busy", 128'(busy), 128'(1));
    check("mid_queued", 128'(exp_q.size()), 128'(3));
    reset = 1'b0;
    exp_q.delete();
    tick();
    check("mid_rst_rsp", 128'(mem_rsp), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_grant", 128'(req_grant), 128'(1));
    reset = 1'b1;
    rcvd  = 1'b1;
    s0    = n_stale;
    repeat (12) tick();
    check("no_stale", 128'(n_stale - s0), 128'(0));
    rcvd = 1'b0;

    // Random traffic over a small pool of fully initialised words.
    for (int k = 0; k < 8; k++) begin
      pool[k] = (k * 131 + 7) % 1024;
      send_one(mk(ACC_WRITE, 4'(k), {19'($urandom), 10'(pool[k]), 3'($urandom)}, 8'hFF,
                  {$urandom, $urandom}), seen, lat);
    end
    r0 = n_rsp;
    for (int c = 0; c < 400; c++) begin
      if (!req.vld || last_acc) begin
        if ($urandom_range(3, 0) != 0) req = rand_req();
        else req.vld = 1'b0;
      end
      rcvd = 1'($urandom);
      tick();
    end
    rcvd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (req.vld && last_acc) req.vld = 1'b0;
      if (!req.vld && exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
    check("drain_idle", 128'(busy), 128'(0));
    check("rand_stale", 128'(n_stale - s0), 128'(0));
    check("rand_progress", 128'(n_rsp > r0), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
